eclk_phase_aligner: RTL and testbench
=====================================

Name: eclk_phase_aligner

Overview:
- Phase-search controller that consumes the filtered eclk-detect status (0/1, from the sclk-domain jitter filter).
- Drives the PLL dynamic phase-step interface, then waits a fixed settle window after every step before it samples status.
- Searches for the 0->1 status edge and optionally backs off a fixed number of steps.
- Reports done or error to the training sequencer.

Parameters:
- WAIT_CYCLES, 256: settle cycles after each step. Must be >= 2x the filter window (filter window = 128).
- MAX_STEPS, 64: forward-step budget before error. Must be <= 127.
- BACKOFF, 2: reverse steps applied after the edge is found. 0 disables back-off. Must be < MAX_STEPS.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  level. Sampled only in IDLE, DONE or FAIL; a 1 there begins a search.
- status_in  in  1  filtered eclk-detect status. Already in the sclk domain; no synchroniser.
- phase_step  out  1  one-cycle pulse requesting one PLL phase step.
- phase_dir  out  1  step direction: 0 = forward, 1 = reverse. Stable the cycle before phase_step and during it.
- busy  out  1  high from the cycle after start is accepted until DONE or FAIL is entered.
- done  out  1  high in DONE; held until the next accepted start.
- error  out  1  high in FAIL; held until the next accepted start.
- step_cnt  out  7  forward steps issued in the current search.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, mode=FIND_LOW; phase_step, phase_dir, busy, done, error, step_cnt, settle counter and back-off counter all 0.
- Reset mid-search aborts at once. No further step pulses are issued; the PLL phase is not restored.
- States: IDLE, SETTLE, EVAL, STEP, DONE, FAIL. Mode register: FIND_LOW, FIND_HIGH, BACKOFF.
- IDLE/DONE/FAIL with start=1 -> SETTLE next cycle. The same transition sets mode=FIND_LOW, clears step_cnt, done, error and the back-off counter, sets phase_dir=0, sets busy=1.
- start=1 in SETTLE, EVAL or STEP is ignored.
- SETTLE: counter runs 0..WAIT_CYCLES-1 and is cleared on entry. When counter==WAIT_CYCLES-1 -> EVAL. Exactly WAIT_CYCLES cycles are spent in SETTLE.
- EVAL (1 cycle): status_in is sampled here only.
  - FIND_LOW, status=0 -> mode=FIND_HIGH, go to STEP.
  - FIND_LOW, status=1 -> STEP (keep seeking low).
  - FIND_HIGH, status=1, BACKOFF=0 -> DONE.
  - FIND_HIGH, status=1, BACKOFF>0 -> mode=BACKOFF, phase_dir=1, go to STEP.
  - FIND_HIGH, status=0 -> STEP.
  - BACKOFF mode: back-off counter==BACKOFF -> DONE; otherwise STEP. status is ignored in this mode.
- STEP (1 cycle): phase_step=1, then -> SETTLE.
  - Forward step: step_cnt+1.
  - Reverse step: back-off counter+1.
  - Budget check: a forward step is never issued when step_cnt==MAX_STEPS. In that case go to FAIL with no pulse.
- DONE: done=1, busy=0. FAIL: error=1, busy=0. phase_dir is held in both.
- Minimum spacing between phase_step pulses: WAIT_CYCLES+2 cycles.
- step_cnt saturates by construction. No wrap: MAX_STEPS <= 127.
- Total latency from start to done for a search of n forward steps and b back-off steps: (n+b+1)*(WAIT_CYCLES+1) + (n+b) + 1 cycles.

Decomposition:
- Shared package (phase_align_pkg): state and mode encodings (localparams), FILTER_WINDOW=128 constant, elaboration check WAIT_CYCLES >= 2*FILTER_WINDOW.
- One natural sub-module: settle_timer. A counter with clear/start inputs and a one-cycle expire output at WAIT_CYCLES-1.
- The FSM stays in the top module.

Test Plan:
- Status model = 0 for phase steps 0..4, 1 from step 5; start pulse -> FIND_LOW satisfied immediately; 5 forward pulses; 2 reverse pulses with phase_dir=1; done=1; step_cnt=5; pulse spacing = 258 cycles.
- Status stuck at 1 -> 64 forward pulses -> error=1, busy=0, step_cnt=64, no 65th pulse.
- Status 1 at steps 0..2, 0 at 3..9, 1 at 10 -> done after 10 forward and 2 reverse pulses; step_cnt=10.
- BACKOFF=0, status 0 then 1 at step 1 -> one forward pulse, done=1, zero reverse pulses, phase_dir stays 0.
- reset_n low mid-SETTLE (after step 3) -> all outputs 0 asynchronously; after release no pulse until start.
- start held high throughout -> no restart while busy; immediate restart the cycle after DONE, which clears done and step_cnt.

Source files
------------

// File: rtl/phase_align_pkg.sv
// Shared encodings and limits for the eclk phase-search controller.
// Also holds the settle-window sanity check used at elaboration.
package phase_align_pkg;

   localparam int FILTER_WINDOW = 128;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETTLE = 3'd1;
   localparam logic [2:0] ST_EVAL   = 3'd2;
   localparam logic [2:0] ST_STEP   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;
   localparam logic [2:0] ST_FAIL   = 3'd5;

   localparam logic [1:0] MODE_FIND_LOW  = 2'd0;
   localparam logic [1:0] MODE_FIND_HIGH = 2'd1;
   localparam logic [1:0] MODE_BACKOFF   = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_SETTLE = ST_SETTLE,
      S_EVAL   = ST_EVAL,
      S_STEP   = ST_STEP,
      S_DONE   = ST_DONE,
      S_FAIL   = ST_FAIL
   } state_t;

   typedef enum logic [1:0] {
      M_FIND_LOW  = MODE_FIND_LOW,
      M_FIND_HIGH = MODE_FIND_HIGH,
      M_BACKOFF   = MODE_BACKOFF
   } mode_t;

   // The status filter needs two full windows after a step before its
   // output reflects the new phase.
   function automatic bit wait_cycles_ok(int unsigned wait_cycles);
      return wait_cycles >= 2 * FILTER_WINDOW;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-window counter: runs 0..WAIT_CYCLES-1 while enabled and flags
// the last count with a one-cycle expire.
module settle_timer #(
   parameter int WAIT_CYCLES = 256
) (
   input  logic sclk,
   input  logic reset_n,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int CW = $clog2(WAIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

   logic [CW-1:0] cnt;

   assign expire = run && !clear && (cnt == LAST);

   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear || expire) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/eclk_phase_aligner.sv
// Phase-search controller: steps the PLL phase until the filtered eclk
// status shows a 0->1 edge, then optionally backs off a few steps.
module eclk_phase_aligner
   import phase_align_pkg::*;
#(
   parameter int WAIT_CYCLES = 256,
   parameter int MAX_STEPS   = 64,
   parameter int BACKOFF     = 2
) (
   input  logic       sclk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       status_in,
   output logic       phase_step,
   output logic       phase_dir,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [6:0] step_cnt
);

   if (!wait_cycles_ok(WAIT_CYCLES)) begin : g_bad_wait
      $error("WAIT_CYCLES must be at least twice FILTER_WINDOW");
   end
   if (MAX_STEPS > 127 || MAX_STEPS < 1) begin : g_bad_max
      $error("MAX_STEPS must be in 1..127");
   end
   if (BACKOFF < 0 || BACKOFF >= MAX_STEPS) begin : g_bad_backoff
      $error("BACKOFF must be in 0..MAX_STEPS-1");
   end

   localparam logic [6:0] MAX_C       = 7'(MAX_STEPS);
   localparam logic [6:0] BACKOFF_C   = 7'(BACKOFF);
   localparam bit         HAS_BACKOFF = (BACKOFF != 0);

   state_t     state;
   mode_t      mode;
   logic [6:0] bo_cnt;
   logic       tmr_clear;
   logic       tmr_run;
   logic       tmr_expire;

   // Holding the timer clear outside SETTLE makes every entry start at 0.
   assign tmr_run   = (state == S_SETTLE);
   assign tmr_clear = !tmr_run;

   settle_timer #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_settle (
      .sclk    (sclk),
      .reset_n (reset_n),
      .clear   (tmr_clear),
      .run     (tmr_run),
      .expire  (tmr_expire)
   );

   // phase_step is registered out of STEP, so it rises one cycle after
   // phase_dir settles and lands in the first SETTLE cycle.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         mode       <= M_FIND_LOW;
         phase_step <= 1'b0;
         phase_dir  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         step_cnt   <= '0;
         bo_cnt     <= '0;
      end else begin
         phase_step <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_FAIL: begin
               if (start) begin
                  state     <= S_SETTLE;
                  mode      <= M_FIND_LOW;
                  step_cnt  <= '0;
                  bo_cnt    <= '0;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  phase_dir <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_SETTLE: begin
               if (tmr_expire) state <= S_EVAL;
            end
            S_EVAL: begin
               case (mode)
                  M_FIND_LOW: begin
                     if (!status_in) mode <= M_FIND_HIGH;
                     state <= S_STEP;
                  end
                  M_FIND_HIGH: begin
                     if (!status_in) begin
                        state <= S_STEP;
                     end else if (!HAS_BACKOFF) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        mode      <= M_BACKOFF;
                        phase_dir <= 1'b1;
                        state     <= S_STEP;
                     end
                  end
                  default: begin
                     if (bo_cnt == BACKOFF_C) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                     end else begin
                        state <= S_STEP;
                     end
                  end
               endcase
            end
            S_STEP: begin
               if (mode == M_BACKOFF) begin
                  bo_cnt     <= bo_cnt + 7'd1;
                  phase_step <= 1'b1;
                  state      <= S_SETTLE;
               end else if (step_cnt == MAX_C) begin
                  // Budget exhausted: no pulse for the step that would exceed it.
                  state <= S_FAIL;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  step_cnt   <= step_cnt + 7'd1;
                  phase_step <= 1'b1;
                  state      <= S_SETTLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eclk_phase_aligner.sv
// Scoreboard bench: searches push expected pulses/terminal events with
// absolute cycle times; a monitor pops and compares as the DUT emits them.
module tb_eclk_phase_aligner;

   localparam int W = 256;
   localparam int P = W + 2;

   logic sclk = 1'b0;
   logic reset_n = 1'b0;
   logic start_a = 1'b0;
   logic start_b = 1'b0;
   logic status_in;
   logic sel = 1'b0;

   logic       a_step, a_dir, a_busy, a_done, a_err;
   logic [6:0] a_cnt;
   logic       b_step, b_dir, b_busy, b_done, b_err;
   logic [6:0] b_cnt;

   always #5 sclk = ~sclk;

   eclk_phase_aligner #(.WAIT_CYCLES(W), .MAX_STEPS(64), .BACKOFF(2)) dut (
      .sclk(sclk), .reset_n(reset_n), .start(start_a), .status_in(status_in),
      .phase_step(a_step), .phase_dir(a_dir), .busy(a_busy), .done(a_done),
      .error(a_err), .step_cnt(a_cnt));

   eclk_phase_aligner #(.WAIT_CYCLES(W), .MAX_STEPS(64), .BACKOFF(0)) dut_nb (
      .sclk(sclk), .reset_n(reset_n), .start(start_b), .status_in(status_in),
      .phase_step(b_step), .phase_dir(b_dir), .busy(b_busy), .done(b_done),
      .error(b_err), .step_cnt(b_cnt));

   logic       m_step, m_dir, m_busy, m_done, m_err;
   logic [6:0] m_cnt;
   assign m_step = sel ? b_step : a_step;
   assign m_dir  = sel ? b_dir  : a_dir;
   assign m_busy = sel ? b_busy : a_busy;
   assign m_done = sel ? b_done : a_done;
   assign m_err  = sel ? b_err  : a_err;
   assign m_cnt  = sel ? b_cnt  : a_cnt;

   typedef struct {
      int kind;   // 0 pulse, 1 done, 2 error
      int dir;
      int cnt;
      int t;
   } ev_t;

   ev_t q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  pos = 0;
   int  model = 1;

   always @(posedge sclk) cyc <= cyc + 1;

   // PLL + filter model: status as a function of net phase position.
   function automatic logic stat_fn(int m, int p);
      case (m)
         1: return p >= 5;
         2: return 1'b1;
         3: return (p <= 2) || (p >= 10);
         4: return p >= 1;
         default: return 1'b0;
      endcase
   endfunction
   assign status_in = stat_fn(model, pos);

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // nf forward pulses, nb reverse pulses, then a done (endk=1), an error
   // (endk=2) or nothing (endk=0). c0 = cyc at the negedge start was raised.
   task automatic push_search(int c0, int nf, int nb, int endk, int enddir);
      int m;
      m = nf + nb;
      for (int j = 1; j <= nf; j++) q.push_back('{0, 0, j, c0 + j*P + 1});
      for (int j = 1; j <= nb; j++) q.push_back('{0, 1, nf, c0 + (nf+j)*P + 1});
      if (endk == 1) q.push_back('{1, enddir, nf, c0 + (m+1)*(W+1) + m + 1});
      if (endk == 2) q.push_back('{2, 0, nf, c0 + (nf+1)*P + 1});
   endtask

   task automatic drain(string name, int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge sclk);
         n++;
      end
      if (q.size() != 0) begin
         chk(name, q.size(), 0);
         q.delete();
      end
      repeat (4) @(negedge sclk);
   endtask

   task automatic pulse_start_a(output int c0);
      @(negedge sclk);
      c0 = cyc;
      start_a = 1'b1;
      @(negedge sclk);
      start_a = 1'b0;
      chk("busy_after_start", a_busy, 1);
   endtask

   // Monitor
   initial begin
      logic pd, pdone, perr;
      ev_t  ev;
      pd = 1'b0; pdone = 1'b0; perr = 1'b0;
      forever begin
         @(negedge sclk);
         if (m_step === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_pulse", 1, 0);
            end else begin
               ev = q.pop_front();
               chk("pulse_kind", 0, ev.kind);
               chk("pulse_time", cyc, ev.t);
               chk("pulse_dir", m_dir, ev.dir);
               chk("pulse_dir_setup", pd, ev.dir);
               chk("pulse_step_cnt", m_cnt, ev.cnt);
               chk("pulse_busy", m_busy, 1);
            end
            pos += (m_dir === 1'b1) ? -1 : 1;
         end
         if ((m_done === 1'b1 && !pdone) || (m_err === 1'b1 && !perr)) begin
            if (q.size() == 0) begin
               chk("unexpected_end", 1, 0);
            end else begin
               ev = q.pop_front();
               chk("end_kind", (m_err === 1'b1) ? 2 : 1, ev.kind);
               chk("end_time", cyc, ev.t);
               chk("end_step_cnt", m_cnt, ev.cnt);
               chk("end_busy", m_busy, 0);
               chk("end_dir", m_dir, ev.dir);
            end
         end
         pd = m_dir; pdone = m_done; perr = m_err;
      end
   end

   initial begin
      int c0, d;

      // Reset state
      #12;
      chk("rst_step", a_step, 0);
      chk("rst_dir", a_dir, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_error", a_err, 0);
      chk("rst_step_cnt", a_cnt, 0);
      chk("rst_nb_busy", b_busy, 0);
      @(negedge sclk);
      reset_n = 1'b1;
      repeat (3) @(negedge sclk);

      // T1: edge at position 5, back off 2
      model = 1; pos = 0;
      pulse_start_a(c0);
      push_search(c0, 5, 2, 1, 1);
      drain("t1_timeout", 10*P);
      chk("t1_done", a_done, 1);
      chk("t1_step_cnt", a_cnt, 5);
      chk("t1_dir_held", a_dir, 1);

      // T2: status stuck high, budget runs out
      model = 2; pos = 0;
      pulse_start_a(c0);
      chk("t2_done_cleared", a_done, 0);
      push_search(c0, 64, 0, 2, 0);
      drain("t2_timeout", 70*P);
      repeat (W + 10) @(negedge sclk);
      chk("t2_error", a_err, 1);
      chk("t2_busy", a_busy, 0);
      chk("t2_step_cnt", a_cnt, 64);

      // T3: high, then low, then high again at position 10
      model = 3; pos = 0;
      pulse_start_a(c0);
      chk("t3_error_cleared", a_err, 0);
      push_search(c0, 10, 2, 1, 1);
      drain("t3_timeout", 15*P);
      chk("t3_done", a_done, 1);
      chk("t3_step_cnt", a_cnt, 10);

      // T5: reset in the settle window after the third step
      model = 1; pos = 0;
      pulse_start_a(c0);
      push_search(c0, 3, 0, 0, 0);
      drain("t5_timeout", 5*P);
      repeat (100) @(negedge sclk);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_rst_busy", a_busy, 0);
      chk("t5_rst_step_cnt", a_cnt, 0);
      chk("t5_rst_done", a_done, 0);
      chk("t5_rst_error", a_err, 0);
      chk("t5_rst_dir", a_dir, 0);
      chk("t5_rst_step", a_step, 0);
      repeat (3) @(negedge sclk);
      reset_n = 1'b1;
      repeat (3*P) @(negedge sclk);
      chk("t5_idle_busy", a_busy, 0);
      chk("t5_idle_step_cnt", a_cnt, 0);

      // T6: start held high; restart only once DONE is reached
      model = 1; pos = 0;
      @(negedge sclk);
      c0 = cyc;
      start_a = 1'b1;
      push_search(c0, 5, 2, 1, 1);
      d = c0 + 8*P;
      push_search(d, 2, 2, 1, 1);   // resumes from position 3
      while (cyc < d + 1) @(negedge sclk);
      chk("t6_restart_done", a_done, 0);
      chk("t6_restart_busy", a_busy, 1);
      chk("t6_restart_step_cnt", a_cnt, 0);
      start_a = 1'b0;
      drain("t6_timeout", 7*P);
      chk("t6_done", a_done, 1);
      chk("t6_step_cnt", a_cnt, 2);

      // T4: no back-off instance
      sel = 1'b1; model = 4; pos = 0;
      @(negedge sclk);
      c0 = cyc;
      start_b = 1'b1;
      @(negedge sclk);
      start_b = 1'b0;
      chk("t4_busy", b_busy, 1);
      push_search(c0, 1, 0, 1, 0);
      drain("t4_timeout", 4*P);
      repeat (P) @(negedge sclk);
      chk("t4_done", b_done, 1);
      chk("t4_step_cnt", b_cnt, 1);
      chk("t4_dir", b_dir, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
